// File: rtl/anim_sprite_bitmap.sv
// Multi-frame writable sprite bitmap with a startOfFrame-driven animation
// sequencer. Two-cycle read pipeline: stage 1 is a synchronous RAM read at
// the pixel address, stage 2 registers the pixel colour and drawingRequest.
// Optional feature macro: ANIM_PINGPONG_EN (bouncing frame sequence).
module anim_sprite_bitmap #(
    parameter int unsigned OBJECT_NUMBER_OF_X_BITS = 5,
    parameter int unsigned OBJECT_NUMBER_OF_Y_BITS = 5,
    parameter int unsigned NUM_FRAMES              = 4,
    parameter int unsigned FRAME_HOLD              = 8,
    parameter int unsigned COLOR_BITS              = 8,
    parameter logic [COLOR_BITS-1:0] TRANSPARENT_ENCODING = 8'hFF,
    localparam int unsigned FRAME_BITS = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               startOfFrame,
    input  logic                               anim_enable,
    input  logic                               anim_restart,
    input  logic                               flip_x,
    input  logic [OBJECT_NUMBER_OF_X_BITS:0]   offsetX,
    input  logic [OBJECT_NUMBER_OF_Y_BITS:0]   offsetY,
    input  logic                               InsideRectangle,
    input  logic                               wr_en,
    input  logic [FRAME_BITS-1:0]              wr_frame,
    input  logic [OBJECT_NUMBER_OF_X_BITS-1:0] wr_x,
    input  logic [OBJECT_NUMBER_OF_Y_BITS-1:0] wr_y,
    input  logic [COLOR_BITS-1:0]              wr_data,
    output logic                               drawingRequest,
    output logic [COLOR_BITS-1:0]              RGBout,
    output logic [FRAME_BITS-1:0]              cur_frame
);

    localparam int unsigned XB        = OBJECT_NUMBER_OF_X_BITS;
    localparam int unsigned YB        = OBJECT_NUMBER_OF_Y_BITS;
    localparam int unsigned HOLD_BITS = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int unsigned ADDR_BITS = FRAME_BITS + YB + XB;
    localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
    localparam logic [FRAME_BITS-1:0] LAST_FRAME = FRAME_BITS'(NUM_FRAMES - 1);
    localparam logic [HOLD_BITS-1:0]  LAST_HOLD  = HOLD_BITS'(FRAME_HOLD - 1);

    logic [COLOR_BITS-1:0] r_mem [DEPTH];
    logic [COLOR_BITS-1:0] r_rd_data;
    logic                  r_valid;
    logic                  r_drawing;
    logic [COLOR_BITS-1:0] r_rgb;
    logic [FRAME_BITS-1:0] r_cur_frame;
    logic [HOLD_BITS-1:0]  r_hold_cnt;
    logic                  r_flip_latched;
`ifdef ANIM_PINGPONG_EN
    logic                  r_dir_up;
    logic                  w_next_dir_up;
`endif

    logic [XB-1:0]         w_x;
    logic                  w_valid;
    logic [ADDR_BITS-1:0]  w_rd_addr;
    logic [ADDR_BITS-1:0]  w_wr_addr;
    logic [FRAME_BITS-1:0] w_next_frame;

    // Pixel address (with latched mirroring) and in-box qualification
    assign w_x       = r_flip_latched ? ~offsetX[XB-1:0] : offsetX[XB-1:0];
    assign w_valid   = InsideRectangle & ~offsetX[XB] & ~offsetY[YB];
    assign w_rd_addr = {r_cur_frame, offsetY[YB-1:0], w_x};
    assign w_wr_addr = {wr_frame, wr_y, wr_x};

    // Frame that follows the current one on an advance
    always_comb begin
        w_next_frame = r_cur_frame;
`ifdef ANIM_PINGPONG_EN
        w_next_dir_up = r_dir_up;
        if (NUM_FRAMES > 1) begin
            if (r_dir_up) begin
                if (r_cur_frame == LAST_FRAME) begin
                    w_next_frame  = r_cur_frame - FRAME_BITS'(1);
                    w_next_dir_up = 1'b0;
                end else begin
                    w_next_frame = r_cur_frame + FRAME_BITS'(1);
                end
            end else begin
                if (r_cur_frame == '0) begin
                    w_next_frame  = FRAME_BITS'(1);
                    w_next_dir_up = 1'b1;
                end else begin
                    w_next_frame = r_cur_frame - FRAME_BITS'(1);
                end
            end
        end
`else
        if (r_cur_frame != LAST_FRAME) begin
            w_next_frame = r_cur_frame + FRAME_BITS'(1);
        end else begin
            w_next_frame = '0;
        end
`endif
    end

    // Animation sequencer: restart beats advance; flip latched per video frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_frame    <= '0;
            r_hold_cnt     <= '0;
            r_flip_latched <= 1'b0;
`ifdef ANIM_PINGPONG_EN
            r_dir_up       <= 1'b1;
`endif
        end else begin
            if (startOfFrame) begin
                r_flip_latched <= flip_x;
            end
            if (anim_restart) begin
                r_cur_frame <= '0;
                r_hold_cnt  <= '0;
`ifdef ANIM_PINGPONG_EN
                r_dir_up    <= 1'b1;
`endif
            end else if (startOfFrame && anim_enable) begin
                if (r_hold_cnt == LAST_HOLD) begin
                    r_hold_cnt  <= '0;
                    r_cur_frame <= w_next_frame;
`ifdef ANIM_PINGPONG_EN
                    r_dir_up    <= w_next_dir_up;
`endif
                end else begin
                    r_hold_cnt <= r_hold_cnt + HOLD_BITS'(1);
                end
            end
        end
    end

    // Bitmap write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[w_wr_addr] <= wr_data;
        end
    end

    // Stage 1 read: returns pre-write data on a same-address collision
    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Stage 1 valid bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_valid;
        end
    end

    // Stage 2: registered pixel colour and opacity
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb     <= TRANSPARENT_ENCODING;
            r_drawing <= 1'b0;
        end else begin
            r_rgb     <= r_valid ? r_rd_data : TRANSPARENT_ENCODING;
            r_drawing <= r_valid && (r_rd_data != TRANSPARENT_ENCODING);
        end
    end

    assign RGBout         = r_rgb;
    assign drawingRequest = r_drawing;
    assign cur_frame      = r_cur_frame;

endmodule

// File: tb/tb_anim_sprite_bitmap.sv
// Directed self-checking bench for anim_sprite_bitmap (default parameters).
// Pixel expectations go into a queue when driven and are checked two cycles
// later; frame expectations come from the documented sequences.
module tb_anim_sprite_bitmap;

    typedef struct packed {
        logic       ce;
        logic [7:0] rgb;
        logic       dr;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       startOfFrame;
    logic       anim_enable;
    logic       anim_restart;
    logic       flip_x;
    logic [5:0] offsetX;
    logic [5:0] offsetY;
    logic       InsideRectangle;
    logic       wr_en;
    logic [1:0] wr_frame;
    logic [4:0] wr_x;
    logic [4:0] wr_y;
    logic [7:0] wr_data;
    logic       drawingRequest;
    logic [7:0] RGBout;
    logic [1:0] cur_frame;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    int   frame_tbl[8];

    anim_sprite_bitmap dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .anim_enable    (anim_enable),
        .anim_restart   (anim_restart),
        .flip_x         (flip_x),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .InsideRectangle(InsideRectangle),
        .wr_en          (wr_en),
        .wr_frame       (wr_frame),
        .wr_x           (wr_x),
        .wr_y           (wr_y),
        .wr_data        (wr_data),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .cur_frame      (cur_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: queue the expectation for the inputs now driven, then check
    // the entry driven on the previous cycle (two edges of latency).
    task automatic tick(input logic ce, input logic [7:0] er, input logic ed);
        exp_t e;
        q.push_back('{ce: ce, rgb: er, dr: ed});
        @(negedge clk);
        if (q.size() == 2) begin
            e = q.pop_front();
            if (e.ce) begin
                chk("pixel_rgb", 32'(RGBout), 32'(e.rgb));
                chk("pixel_draw", 32'(drawingRequest), 32'(e.dr));
            end
        end
    endtask

    task automatic rd(input logic [5:0] x, input logic [5:0] y, input logic ins,
                      input logic [7:0] er, input logic ed);
        offsetX = x;
        offsetY = y;
        InsideRectangle = ins;
        tick(1'b1, er, ed);
    endtask

    task automatic wr(input logic [1:0] f, input logic [4:0] x, input logic [4:0] y,
                      input logic [7:0] d);
        wr_frame = f;
        wr_x = x;
        wr_y = y;
        wr_data = d;
        wr_en = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        wr_en = 1'b0;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        startOfFrame = 1'b0;
    endtask

    initial begin
`ifdef ANIM_PINGPONG_EN
        frame_tbl = '{0, 1, 2, 3, 2, 1, 0, 1};
`else
        frame_tbl = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        // Reset with the probed pixel made transparent so post-reset reads are defined
        reset = 1'b1;
        startOfFrame = 1'b0;
        anim_enable = 1'b1;
        anim_restart = 1'b0;
        flip_x = 1'b0;
        offsetX = 6'd3;
        offsetY = 6'd4;
        InsideRectangle = 1'b1;
        wr_en = 1'b1;
        wr_frame = 2'd0;
        wr_x = 5'd3;
        wr_y = 5'd4;
        wr_data = 8'hFF;
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("reset_draw", 32'(drawingRequest), 32'd0);
            chk("reset_rgb", 32'(RGBout), 32'hFF);
            chk("reset_frame", 32'(cur_frame), 32'd0);
            if (c < 2) @(negedge clk);
        end

        // Basic writes and exact two-cycle read latency
        wr(2'd0, 5'd5, 5'd7, 8'h33);
        wr(2'd1, 5'd5, 5'd7, 8'hF9);
        rd(6'd3, 6'd4, 1'b1, 8'hFF, 1'b0);
        rd(6'd5, 6'd7, 1'b1, 8'h33, 1'b1);
        rd(6'd3, 6'd4, 1'b1, 8'hFF, 1'b0);
        wr(2'd0, 5'd5, 5'd7, 8'hFF);
        rd(6'd5, 6'd7, 1'b1, 8'hFF, 1'b0);

        // Read-before-write on a same-cycle collision
        wr(2'd0, 5'd5, 5'd7, 8'h33);
        wr_frame = 2'd0;
        wr_x = 5'd5;
        wr_y = 5'd7;
        wr_data = 8'h00;
        wr_en = 1'b1;
        rd(6'd5, 6'd7, 1'b1, 8'h33, 1'b1);
        wr_en = 1'b0;
        rd(6'd5, 6'd7, 1'b1, 8'h00, 1'b1);

        // Outside the box, or offset upper bit set: transparent
        rd(6'd5, 6'd7, 1'b0, 8'hFF, 1'b0);
        rd(6'd37, 6'd7, 1'b1, 8'hFF, 1'b0);
        rd(6'd5, 6'd39, 1'b1, 8'hFF, 1'b0);

        // Sequencer: one step every 8 pulses
        for (int p = 1; p <= 56; p++) begin
            sof();
            chk($sformatf("seq_frame_p%0d", p), 32'(cur_frame), 32'(frame_tbl[p / 8]));
        end

        // Disabled sequencer holds the frame
        anim_enable = 1'b0;
        for (int p = 0; p < 5; p++) begin
            sof();
            chk("frozen_frame", 32'(cur_frame), 32'(frame_tbl[7]));
        end
        anim_enable = 1'b1;

        // Restart alone, then reach frame 2 with hold count 7
        anim_restart = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        anim_restart = 1'b0;
        chk("restart_frame", 32'(cur_frame), 32'd0);
        for (int p = 0; p < 23; p++) sof();
        chk("pre_restart_frame", 32'(cur_frame), 32'd2);

        // Restart coincident with startOfFrame wins and clears the hold count
        anim_restart = 1'b1;
        sof();
        anim_restart = 1'b0;
        chk("restart_sof_frame", 32'(cur_frame), 32'd0);
        for (int p = 0; p < 7; p++) sof();
        chk("hold_cleared_frame", 32'(cur_frame), 32'd0);
        sof();
        chk("after_hold_frame", 32'(cur_frame), 32'd1);

        // Mirroring only takes effect after the next startOfFrame
        wr(2'd1, 5'd0, 5'd2, 8'h11);
        wr(2'd1, 5'd31, 5'd2, 8'h22);
        flip_x = 1'b1;
        rd(6'd0, 6'd2, 1'b1, 8'h11, 1'b1);
        sof();
        rd(6'd0, 6'd2, 1'b1, 8'h22, 1'b1);
        rd(6'd31, 6'd2, 1'b1, 8'h11, 1'b1);
        flip_x = 1'b0;
        rd(6'd0, 6'd2, 1'b1, 8'h22, 1'b1);
        rd(6'd26, 6'd7, 1'b1, 8'hF9, 1'b1);
        sof();
        rd(6'd0, 6'd2, 1'b1, 8'h11, 1'b1);
        rd(6'd5, 6'd7, 1'b1, 8'hF9, 1'b1);
        chk("final_frame", 32'(cur_frame), 32'd1);

        // Drain the pipeline so the last reads are compared
        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
